// File: rtl/memory_stage_if.sv
// Bundle between the Execute stage and the Memory stage.
//   master : Execute side; drives the op bundle, observes the write-back bundle and sp.
//   slave  : Memory stage; consumes the op bundle, drives the write-back bundle and sp.
// Op bundle      : in_valid, mem_read, mem_write, push, pop, reg_write_in, write_addr_in,
//                  alu_result, store_data
// Write-back side: out_valid, reg_write_out, write_addr_out, wb_data, sp, op_error
interface memory_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11
);
  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic              push;
  logic              pop;
  logic              reg_write_in;
  logic [2:0]        write_addr_in;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;

  logic              out_valid;
  logic              reg_write_out;
  logic [2:0]        write_addr_out;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] sp;
  logic              op_error;

  modport master (
    output in_valid, mem_read, mem_write, push, pop, reg_write_in, write_addr_in,
           alu_result, store_data,
    input  out_valid, reg_write_out, write_addr_out, wb_data, sp, op_error
  );

  modport slave (
    input  in_valid, mem_read, mem_write, push, pop, reg_write_in, write_addr_in,
           alu_result, store_data,
    output out_valid, reg_write_out, write_addr_out, wb_data, sp, op_error
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of the 16-bit pipeline: latches the Execute result, performs one data-memory
// access per valid op (load, store, push or pop), owns the stack pointer and the word-addressed
// data memory, and presents a registered write-back bundle one cycle later.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : memory_stage_if.slave, op bundle in / write-back bundle, sp and op_error out
module memory_stage #(
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        ADDR_W   = 11,
  parameter logic [ADDR_W-1:0]  SP_RESET = {ADDR_W{1'b1}}
) (
  input logic            clk,
  input logic            rst,
  memory_stage_if.slave  bus
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] spQ, spD;
  logic              outValidQ;
  logic              regWriteQ;
  logic [2:0]        writeAddrQ;
  logic [DATA_W-1:0] wbDataQ, wbD;
  logic              opErrorQ, opErrorD;

  logic [ADDR_W-1:0] addr;
  logic [2:0]        opCount;
  logic              multiOp;
  logic              doPush, doPop, doStore, doLoad;
  logic              overflow, underflow;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic              rdFromMem;
  logic [ADDR_W-1:0] rdAddr;

  always_comb begin
    addr      = bus.alu_result[ADDR_W-1:0];
    opCount   = 3'(bus.mem_read) + 3'(bus.mem_write) + 3'(bus.push) + 3'(bus.pop);
    multiOp   = opCount > 3'd1;
    // Priority push > pop > mem_write > mem_read; only the winner executes.
    doPush    = bus.push;
    doPop     = !bus.push && bus.pop;
    doStore   = !bus.push && !bus.pop && bus.mem_write;
    doLoad    = !bus.push && !bus.pop && !bus.mem_write && bus.mem_read;
    overflow  = doPush && (spQ == '0);
    underflow = doPop && (spQ == SP_RESET);

    spD       = spQ;
    memWe     = 1'b0;
    memAddr   = addr;
    rdFromMem = 1'b0;
    rdAddr    = addr;
    wbD       = bus.alu_result;
    opErrorD  = 1'b0;

    if (bus.in_valid) begin
      opErrorD = multiOp || overflow || underflow;
      if (doPush && !overflow) begin
        spD     = spQ - ADDR_W'(1);
        memWe   = 1'b1;
        memAddr = spQ;
      end
      if (doPop) begin
        if (underflow) begin
          wbD = '0;
        end else begin
          spD       = spQ + ADDR_W'(1);
          rdFromMem = 1'b1;
          rdAddr    = spQ + ADDR_W'(1);
        end
      end
      if (doStore) memWe = 1'b1;
      if (doLoad) rdFromMem = 1'b1;
    end

    // An op presented during reset is discarded, including its memory write.
    if (rst) memWe = 1'b0;
  end

  // Write at the sampling edge; a read on the next op sees it, which gives N -> N+1 forwarding.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= bus.store_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spQ        <= SP_RESET;
      outValidQ  <= 1'b0;
      regWriteQ  <= 1'b0;
      writeAddrQ <= '0;
      wbDataQ    <= '0;
      opErrorQ   <= 1'b0;
    end else begin
      spQ       <= spD;
      outValidQ <= bus.in_valid;
      regWriteQ <= bus.in_valid && bus.reg_write_in;
      opErrorQ  <= opErrorD;
      if (bus.in_valid) begin
        writeAddrQ <= bus.write_addr_in;
        // Synchronous read returns the contents as stored before this edge.
        wbDataQ    <= rdFromMem ? mem[rdAddr] : wbD;
      end
    end
  end

  assign bus.sp             = spQ;
  assign bus.out_valid      = outValidQ;
  assign bus.reg_write_out  = regWriteQ;
  assign bus.write_addr_out = writeAddrQ;
  assign bus.wb_data        = wbDataQ;
  assign bus.op_error       = opErrorQ;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DATA_W(16), .ADDR_W(11)) bus ();

  memory_stage #(.DATA_W(16), .ADDR_W(11), .SP_RESET(11'h7FF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input logic v, input logic rd, input logic wr, input logic ps,
                       input logic pp, input logic rw, input logic [2:0] wa,
                       input logic [15:0] alu, input logic [15:0] sd);
    bus.in_valid      = v;
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.push          = ps;
    bus.pop           = pp;
    bus.reg_write_in  = rw;
    bus.write_addr_in = wa;
    bus.alu_result    = alu;
    bus.store_data    = sd;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    step();
    tests++; if (bus.sp !== 11'h7FF) begin fails++; $display("FAIL reset_sp got %h want 7ff", bus.sp); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.wb_data !== 16'h0) begin fails++; $display("FAIL reset_wb_data got %h want 0000", bus.wb_data); end
    tests++; if (bus.op_error !== 1'b0) begin fails++; $display("FAIL reset_op_error got %b want 0", bus.op_error); end
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0010, 16'hBEEF);
    step();
    tests++; if (bus.wb_data !== 16'h0010) begin fails++; $display("FAIL store_wb got %h want 0010", bus.wb_data); end
    tests++; if (bus.op_error !== 1'b0) begin fails++; $display("FAIL store_err got %b want 0", bus.op_error); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0010, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'hBEEF) begin fails++; $display("FAIL load_wb got %h want beef", bus.wb_data); end
    tests++; if (bus.write_addr_out !== 3'd3) begin fails++; $display("FAIL load_waddr got %0d want 3", bus.write_addr_out); end
    tests++; if (bus.reg_write_out !== 1'b1) begin fails++; $display("FAIL load_regwr got %b want 1", bus.reg_write_out); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL load_valid got %b want 1", bus.out_valid); end
  endtask

  task automatic test_stack();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0001, 16'h1234);
    step();
    tests++; if (bus.sp !== 11'h7FE) begin fails++; $display("FAIL push1_sp got %h want 7fe", bus.sp); end
    tests++; if (bus.op_error !== 1'b0) begin fails++; $display("FAIL push1_err got %b want 0", bus.op_error); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0002, 16'h5678);
    step();
    tests++; if (bus.sp !== 11'h7FD) begin fails++; $display("FAIL push2_sp got %h want 7fd", bus.sp); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0000, 16'h0000);
    step();
    tests++; if (bus.sp !== 11'h7FE) begin fails++; $display("FAIL pop1_sp got %h want 7fe", bus.sp); end
    tests++; if (bus.wb_data !== 16'h5678) begin fails++; $display("FAIL pop1_wb got %h want 5678", bus.wb_data); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0000, 16'h0000);
    step();
    tests++; if (bus.sp !== 11'h7FF) begin fails++; $display("FAIL pop2_sp got %h want 7ff", bus.sp); end
    tests++; if (bus.wb_data !== 16'h1234) begin fails++; $display("FAIL pop2_wb got %h want 1234", bus.wb_data); end
    idle();
  endtask

  task automatic test_underflow();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h1111, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h0) begin fails++; $display("FAIL uflow_wb got %h want 0000", bus.wb_data); end
    tests++; if (bus.sp !== 11'h7FF) begin fails++; $display("FAIL uflow_sp got %h want 7ff", bus.sp); end
    tests++; if (bus.op_error !== 1'b1) begin fails++; $display("FAIL uflow_err got %b want 1", bus.op_error); end
    tests++; if (bus.reg_write_out !== 1'b1) begin fails++; $display("FAIL uflow_regwr got %b want 1", bus.reg_write_out); end
    idle();
    step();
    tests++; if (bus.op_error !== 1'b0) begin fails++; $display("FAIL uflow_err_clear got %b want 0", bus.op_error); end
  endtask

  task automatic test_overflow();
    // Seed address 0, which the blocked push must not touch.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h5555);
    step();
    for (int k = 0; k < 2047; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'(k));
      step();
    end
    tests++; if (bus.sp !== 11'h000) begin fails++; $display("FAIL oflow_fill_sp got %h want 000", bus.sp); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'hDEAD);
    step();
    tests++; if (bus.sp !== 11'h000) begin fails++; $display("FAIL oflow_sp got %h want 000", bus.sp); end
    tests++; if (bus.op_error !== 1'b1) begin fails++; $display("FAIL oflow_err got %b want 1", bus.op_error); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h5555) begin fails++; $display("FAIL oflow_nowrite got %h want 5555", bus.wb_data); end
    // Last successful push (k=2046) landed at address 1.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h07FE) begin fails++; $display("FAIL oflow_pop got %h want 07fe", bus.wb_data); end
    tests++; if (bus.sp !== 11'h001) begin fails++; $display("FAIL oflow_pop_sp got %h want 001", bus.sp); end
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h8020, 16'h00AA);
    step();
    tests++; if (bus.op_error !== 1'b1) begin fails++; $display("FAIL prio_rw_err got %b want 1", bus.op_error); end
    tests++; if (bus.wb_data !== 16'h8020) begin fails++; $display("FAIL prio_rw_wb got %h want 8020", bus.wb_data); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0020, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h00AA) begin fails++; $display("FAIL prio_rw_load got %h want 00aa", bus.wb_data); end
    tests++; if (bus.op_error !== 1'b0) begin fails++; $display("FAIL prio_load_err got %b want 0", bus.op_error); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0033, 16'h7777);
    step();
    tests++; if (bus.sp !== 11'h7FE) begin fails++; $display("FAIL prio_pp_sp got %h want 7fe", bus.sp); end
    tests++; if (bus.op_error !== 1'b1) begin fails++; $display("FAIL prio_pp_err got %b want 1", bus.op_error); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h7777) begin fails++; $display("FAIL prio_pp_pop got %h want 7777", bus.wb_data); end
    tests++; if (bus.sp !== 11'h7FF) begin fails++; $display("FAIL prio_pp_pop_sp got %h want 7ff", bus.sp); end
  endtask

  task automatic test_passthrough();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'hCAFE, 16'h0000);
    step();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.wb_data !== 16'hCAFE) begin fails++; $display("FAIL pass_wb got %h want cafe", bus.wb_data); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234, 16'h0000);
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hold_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.wb_data !== 16'hCAFE) begin fails++; $display("FAIL hold_wb got %h want cafe", bus.wb_data); end
    tests++; if (bus.reg_write_out !== 1'b0) begin fails++; $display("FAIL hold_regwr got %b want 0", bus.reg_write_out); end
    tests++; if (bus.write_addr_out !== 3'd6) begin fails++; $display("FAIL hold_waddr got %0d want 6", bus.write_addr_out); end
  endtask

  task automatic test_reset_during_push();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1111);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h07FE, 16'h4242);
    step();
    tests++; if (bus.sp !== 11'h7FE) begin fails++; $display("FAIL rstpush_pre_sp got %h want 7fe", bus.sp); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h9999);
    step();
    rst = 1'b0;
    tests++; if (bus.sp !== 11'h7FF) begin fails++; $display("FAIL rstpush_sp got %h want 7ff", bus.sp); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstpush_valid got %b want 0", bus.out_valid); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h07FE, 16'h0000);
    step();
    tests++; if (bus.wb_data !== 16'h4242) begin fails++; $display("FAIL rstpush_mem got %h want 4242", bus.wb_data); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_store_load();
    test_stack();
    test_underflow();
    test_overflow();
    test_priority();
    test_passthrough();
    test_reset_during_push();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
